// File: rtl/power_accumulator.sv
// Windowed accumulator of v*i, v^2 and i^2 over WINDOW offset-corrected ADC sample pairs.
// Three-stage pipeline (offset removal, multiply, accumulate) accepting one sample per cycle.
module power_accumulator #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] OFFSET = 16'h8000,
    parameter int               WINDOW = 17857,
    parameter int               ACC_W  = 2*(WIDTH+1)+16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    sample_valid,
    input  logic [WIDTH-1:0]        v_in,
    input  logic [WIDTH-1:0]        i_in,
    output logic signed [ACC_W-1:0] p_acc,
    output logic [ACC_W-1:0]        v2_acc,
    output logic [ACC_W-1:0]        i2_acc,
    output logic                    result_valid,
    output logic [15:0]             win_cnt
);

    localparam int         PROD_W   = 2*(WIDTH+1);
    localparam logic [15:0] LAST_CNT = 16'(WINDOW-1);

    // Channel 0 = v*i (signed), 1 = v*v, 2 = i*i (both non-negative).
    localparam int NCH = 3;

    logic [15:0]             win_cnt_reg;
    logic                    s0_valid_reg, s0_last_reg;
    logic                    s1_valid_reg, s1_last_reg;
    logic                    result_valid_reg;
    logic signed [WIDTH:0]   v_c_reg, i_c_reg;
    logic signed [WIDTH:0]   v_c_next, i_c_next;
    logic                    is_last;

    logic signed [WIDTH:0]   op_a [NCH];
    logic signed [WIDTH:0]   op_b [NCH];
    logic [PROD_W-1:0]       prod_next [NCH];
    logic [PROD_W-1:0]       prod_reg  [NCH];
    logic [ACC_W-1:0]        prod_ext  [NCH];
    logic [ACC_W-1:0]        acc_sum   [NCH];
    logic [ACC_W-1:0]        acc_reg   [NCH];
    logic [ACC_W-1:0]        out_reg   [NCH];

    assign v_c_next = $signed({1'b0, v_in}) - $signed({1'b0, OFFSET});
    assign i_c_next = $signed({1'b0, i_in}) - $signed({1'b0, OFFSET});
    assign is_last  = (win_cnt_reg == LAST_CNT);

    assign op_a[0] = v_c_reg;
    assign op_b[0] = i_c_reg;
    assign op_a[1] = v_c_reg;
    assign op_b[1] = v_c_reg;
    assign op_a[2] = i_c_reg;
    assign op_b[2] = i_c_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
            logic [PROD_W-1:0] a_ext, b_ext;

            // Low PROD_W bits of the product of sign-extended operands equal the signed product.
            assign a_ext         = {{(PROD_W-WIDTH-1){op_a[gi][WIDTH]}}, op_a[gi]};
            assign b_ext         = {{(PROD_W-WIDTH-1){op_b[gi][WIDTH]}}, op_b[gi]};
            assign prod_next[gi] = a_ext * b_ext;

            if (gi == 0) begin : gen_signed
                assign prod_ext[gi] = {{(ACC_W-PROD_W){prod_reg[gi][PROD_W-1]}}, prod_reg[gi]};
            end else begin : gen_unsigned
                assign prod_ext[gi] = {{(ACC_W-PROD_W){1'b0}}, prod_reg[gi]};
            end

            assign acc_sum[gi] = acc_reg[gi] + prod_ext[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt_reg      <= '0;
            s0_valid_reg     <= 1'b0;
            s0_last_reg      <= 1'b0;
            s1_valid_reg     <= 1'b0;
            s1_last_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
            v_c_reg          <= '0;
            i_c_reg          <= '0;
            for (int k = 0; k < NCH; k++) begin
                prod_reg[k] <= '0;
                acc_reg[k]  <= '0;
                out_reg[k]  <= '0;
            end
        end else begin
            result_valid_reg <= 1'b0;
            if (clr) begin
                // Abort the window in flight; published results stay untouched.
                win_cnt_reg  <= '0;
                s0_valid_reg <= 1'b0;
                s0_last_reg  <= 1'b0;
                s1_valid_reg <= 1'b0;
                s1_last_reg  <= 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    acc_reg[k] <= '0;
                end
            end else begin
                s0_valid_reg <= sample_valid;
                s0_last_reg  <= sample_valid && is_last;
                if (sample_valid) begin
                    v_c_reg     <= v_c_next;
                    i_c_reg     <= i_c_next;
                    win_cnt_reg <= is_last ? 16'd0 : win_cnt_reg + 16'd1;
                end

                s1_valid_reg <= s0_valid_reg;
                s1_last_reg  <= s0_last_reg;
                if (s0_valid_reg) begin
                    for (int k = 0; k < NCH; k++) begin
                        prod_reg[k] <= prod_next[k];
                    end
                end

                // Only one sample reaches this stage per edge, so a window's last
                // sample and the next window's first never collide here.
                if (s1_valid_reg) begin
                    if (s1_last_reg) begin
                        result_valid_reg <= 1'b1;
                        for (int k = 0; k < NCH; k++) begin
                            out_reg[k] <= acc_sum[k];
                            acc_reg[k] <= '0;
                        end
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            acc_reg[k] <= acc_sum[k];
                        end
                    end
                end
            end
        end
    end

    assign p_acc        = out_reg[0];
    assign v2_acc       = out_reg[1];
    assign i2_acc       = out_reg[2];
    assign result_valid = result_valid_reg;
    assign win_cnt      = win_cnt_reg;

endmodule

// File: tb/tb_power_accumulator.sv
// Scoreboard bench for power_accumulator: a WINDOW=4 instance for functional scenarios and a
// WINDOW=65535 instance for the full-scale stress window.
module tb_power_accumulator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, sv4, svf;
    logic [15:0] v_in, i_in;
    logic [49:0] p4, v24, i24, pf, v2f, i2f;
    logic        rv4, rvf;
    logic [15:0] wc4, wcf;

    power_accumulator #(.WIDTH(16), .OFFSET(16'h8000), .WINDOW(4), .ACC_W(50)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .sample_valid(sv4), .v_in(v_in), .i_in(i_in),
        .p_acc(p4), .v2_acc(v24), .i2_acc(i24), .result_valid(rv4), .win_cnt(wc4)
    );

    power_accumulator #(.WIDTH(16), .OFFSET(16'h8000), .WINDOW(65535), .ACC_W(50)) dutf (
        .clk(clk), .rst(rst), .clr(clr), .sample_valid(svf), .v_in(v_in), .i_in(i_in),
        .p_acc(pf), .v2_acc(v2f), .i2_acc(i2f), .result_valid(rvf), .win_cnt(wcf)
    );

    typedef struct {
        logic [49:0] p;
        logic [49:0] v2;
        logic [49:0] i2;
    } res_t;

    res_t   sb[$];
    res_t   last_exp;
    longint mp, mv, mi;
    int     mcnt;
    int     tests_run = 0;
    int     tests_failed = 0;
    int     cyc = 0;
    int     pulses = 0;
    int     pulse_cyc[$];
    int     last_strobe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pop and compare one expected window result per result_valid pulse.
    always @(negedge clk) begin
        if (rst === 1'b1 && rv4 === 1'b1) begin
            res_t e;
            pulses = pulses + 1;
            pulse_cyc.push_back(cyc);
            tests_run = tests_run + 1;
            if (sb.size() == 0) begin
                tests_failed = tests_failed + 1;
                $display("FAIL scoreboard_unexpected_pulse: result_valid at cycle %0d, no result expected", cyc);
            end else begin
                e = sb.pop_front();
                if (p4 !== e.p || v24 !== e.v2 || i24 !== e.i2) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL scoreboard_result: got p=%0d v2=%0d i2=%0d, expected p=%0d v2=%0d i2=%0d",
                             $signed(p4), v24, i24, $signed(e.p), e.v2, e.i2);
                end else begin
                    $display("[TB] result cycle %0d p=%0d v2=%0d i2=%0d ok", cyc, $signed(p4), v24, i24);
                end
            end
        end
    end

    task automatic model_clear();
        mp = 0; mv = 0; mi = 0; mcnt = 0;
    endtask

    task automatic drive(input logic [15:0] v, input logic [15:0] i, input logic do_clr);
        longint vc, ic;
        res_t   r;
        v_in = v; i_in = i; sv4 = 1'b1; clr = do_clr;
        last_strobe = cyc;
        if (do_clr) begin
            model_clear();
        end else begin
            vc = longint'(v) - 32768;
            ic = longint'(i) - 32768;
            mp += vc * ic; mv += vc * vc; mi += ic * ic;
            mcnt++;
            if (mcnt == 4) begin
                r.p = mp[49:0]; r.v2 = mv[49:0]; r.i2 = mi[49:0];
                sb.push_back(r);
                last_exp = r;
                model_clear();
            end
        end
        @(posedge clk); #1;
        sv4 = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (p4 !== 50'd0) begin tests_failed++; $display("FAIL reset_p_acc: got %0d expected 0", p4); end
        tests_run++; if (v24 !== 50'd0) begin tests_failed++; $display("FAIL reset_v2_acc: got %0d expected 0", v24); end
        tests_run++; if (i24 !== 50'd0) begin tests_failed++; $display("FAIL reset_i2_acc: got %0d expected 0", i24); end
        tests_run++; if (rv4 !== 1'b0) begin tests_failed++; $display("FAIL reset_result_valid: got %b expected 0", rv4); end
        tests_run++; if (wc4 !== 16'd0) begin tests_failed++; $display("FAIL reset_win_cnt: got %0d expected 0", wc4); end
        rst = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_constant_positive();
        int p0 = pulses, n0 = pulse_cyc.size(), lat;
        repeat (4) drive(16'h9000, 16'h8800, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        lat = (pulse_cyc.size() > n0) ? pulse_cyc[n0] - last_strobe : -1;
        tests_run++; if (pulses - p0 !== 1) begin tests_failed++; $display("FAIL pos_pulse_count: got %0d expected 1", pulses - p0); end
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL pos_latency: got %0d expected 3", lat); end
        tests_run++; if (p4 !== 50'd33554432) begin tests_failed++; $display("FAIL pos_p_acc: got %0d expected 33554432", $signed(p4)); end
        tests_run++; if (v24 !== 50'd67108864) begin tests_failed++; $display("FAIL pos_v2_acc: got %0d expected 67108864", v24); end
        tests_run++; if (i24 !== 50'd16777216) begin tests_failed++; $display("FAIL pos_i2_acc: got %0d expected 16777216", i24); end
        tests_run++; if (wc4 !== 16'd0) begin tests_failed++; $display("FAIL pos_win_cnt: got %0d expected 0", wc4); end
    endtask

    task automatic test_negative();
        int p0 = pulses;
        logic [49:0] neg_exp;
        neg_exp = 50'd0 - 50'd67108864;
        repeat (4) drive(16'h7000, 16'h9000, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        tests_run++; if (pulses - p0 !== 1) begin tests_failed++; $display("FAIL neg_pulse_count: got %0d expected 1", pulses - p0); end
        tests_run++; if (p4 !== neg_exp) begin tests_failed++; $display("FAIL neg_p_acc: got %0d expected -67108864", $signed(p4)); end
        tests_run++; if (v24 !== 50'd67108864 || i24 !== 50'd67108864) begin
            tests_failed++; $display("FAIL neg_v2_i2: got v2=%0d i2=%0d expected 67108864 both", v24, i24);
        end
    endtask

    task automatic test_back_to_back();
        int p0 = pulses, n0 = pulse_cyc.size(), gap;
        repeat (8) drive(16'h9000, 16'h8800, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        gap = (pulse_cyc.size() >= n0 + 2) ? pulse_cyc[n0+1] - pulse_cyc[n0] : -1;
        tests_run++; if (pulses - p0 !== 2) begin tests_failed++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses - p0); end
        tests_run++; if (gap !== 4) begin tests_failed++; $display("FAIL b2b_pulse_gap: got %0d expected 4", gap); end
        tests_run++; if (p4 !== 50'd33554432) begin tests_failed++; $display("FAIL b2b_p_acc: got %0d expected 33554432", $signed(p4)); end
    endtask

    task automatic test_clr();
        int p0;
        drive(16'hA000, 16'h6000, 1'b0);
        drive(16'hC000, 16'h4000, 1'b0);
        p0 = pulses;
        drive(16'h1234, 16'h5678, 1'b1);
        tests_run++; if (rv4 !== 1'b0) begin tests_failed++; $display("FAIL clr_no_pulse: got result_valid=%b expected 0", rv4); end
        tests_run++; if (p4 !== last_exp.p || v24 !== last_exp.v2 || i24 !== last_exp.i2) begin
            tests_failed++; $display("FAIL clr_hold: got p=%0d v2=%0d i2=%0d expected p=%0d v2=%0d i2=%0d",
                                     $signed(p4), v24, i24, $signed(last_exp.p), last_exp.v2, last_exp.i2);
        end
        tests_run++; if (wc4 !== 16'd0) begin tests_failed++; $display("FAIL clr_win_cnt: got %0d expected 0", wc4); end
        repeat (4) @(posedge clk);
        #1;
        tests_run++; if (pulses !== p0) begin tests_failed++; $display("FAIL clr_spurious_pulse: got %0d pulses expected 0", pulses - p0); end
        drive(16'hA000, 16'h6000, 1'b0);
        drive(16'h8123, 16'h7F00, 1'b0);
        drive(16'hFFFF, 16'h0001, 1'b0);
        drive(16'h8000, 16'hC000, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        tests_run++; if (pulses - p0 !== 1) begin tests_failed++; $display("FAIL clr_result_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_reset_mid_window();
        int p0;
        drive(16'h9000, 16'h9000, 1'b0);
        drive(16'h4000, 16'h2000, 1'b0);
        rst = 1'b0;
        model_clear();
        #1;
        tests_run++; if (p4 !== 50'd0 || v24 !== 50'd0 || i24 !== 50'd0) begin
            tests_failed++; $display("FAIL rst_async_outputs: got p=%0d v2=%0d i2=%0d expected 0", $signed(p4), v24, i24);
        end
        tests_run++; if (wc4 !== 16'd0 || rv4 !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async_cnt: got win_cnt=%0d result_valid=%b expected 0", wc4, rv4);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        p0 = pulses;
        drive(16'h8001, 16'h7FFF, 1'b0);
        drive(16'hF000, 16'h1000, 1'b0);
        drive(16'h0000, 16'hFFFF, 1'b0);
        drive(16'h8800, 16'h8800, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        tests_run++; if (pulses - p0 !== 1) begin tests_failed++; $display("FAIL rst_result_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_full_scale();
        logic [49:0] exp_full;
        logic        seen = 1'b0;
        exp_full = 50'd65535 << 30;
        v_in = 16'h0000; i_in = 16'h0000;
        svf = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        svf = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            if (rvf === 1'b1) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL full_timeout: result_valid %b expected 1 within 10 cycles", seen); end
        tests_run++; if (pf !== exp_full) begin tests_failed++; $display("FAIL full_p_acc: got %0d expected %0d", pf, exp_full); end
        tests_run++; if (v2f !== exp_full || i2f !== exp_full) begin
            tests_failed++; $display("FAIL full_v2_i2: got v2=%0d i2=%0d expected %0d", v2f, i2f, exp_full);
        end
        tests_run++; if (wcf !== 16'd0) begin tests_failed++; $display("FAIL full_win_cnt: got %0d expected 0", wcf); end
        $display("[TB] full-scale window p=%0d v2=%0d i2=%0d", pf, v2f, i2f);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; sv4 = 1'b0; svf = 1'b0;
        v_in = 16'h8000; i_in = 16'h8000;
        model_clear();
        last_exp.p = '0; last_exp.v2 = '0; last_exp.i2 = '0;
        test_reset();
        test_constant_positive();
        test_negative();
        test_back_to_back();
        test_clr();
        test_reset_mid_window();
        test_full_scale();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (sb.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_drain: got %0d pending results expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
